crc_serial_engine: RTL
======================

# crc_serial_engine

Parametrised bit-serial CRC engine that generalises the fixed CRC-16 (x^16+x^12+x^5+1) serial generator to any CRC width, polynomial, init value, output XOR and frame length. It accepts one data bit per cycle over a valid/ready stream and frames the bits with a `start`/`done` protocol. It has two modes:
- Generate mode: emits the frame CRC.
- Check mode: additionally consumes the transmitted CRC and flags a zero residue.

It sits between the serialiser and the link-layer framing logic.

## Interface
Parameters:
- `CRC_W`, 16, CRC width in bits (2..32).
- `POLY`, 16'h1021, generator polynomial without the x^CRC_W term, normal (MSB-first) form.
- `INIT`, 0, CRC register value loaded at frame start.
- `XOR_OUT`, 0, value XORed into the final CRC before it is presented.
- `FRAME_BITS`, 32, payload bits per frame (>=1).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: frame start request.
- `check_en` in 1: sampled with an accepted `start`; 1 selects check mode.
- `abort` in 1: cancels the current frame.
- `in_valid` in 1: `in_bit` is valid.
- `in_bit` in 1: serial data, MSB-first.
- `in_ready` out 1: engine accepts a bit this cycle.
- `busy` out 1: a frame is in progress.
- `done` out 1: one-cycle completion pulse.
- `crc_out` out CRC_W: final CRC (`crc ^ XOR_OUT`), held until the next accepted `start`.
- `crc_ok` out 1: check-mode result, held with `crc_out`.

## Operation
- States: IDLE, DATA, CHECK, DONE.
- Step rule, applied per accepted bit b: `fb = crc[CRC_W-1] ^ b`; `crc_next = {crc[CRC_W-2:0],1'b0} ^ (fb ? POLY : 0)`.
- IDLE or DONE with `start`=1:
  - load `crc`=INIT, clear the bit counter, latch `check_en`;
  - go to DATA.
- DATA:
  - `in_ready`=1; each cycle with `in_valid`=1 applies the step rule and increments the counter.
  - On the FRAME_BITS-th accepted bit: go to CHECK if check mode, otherwise go to DONE.
- CHECK:
  - `in_ready`=1; accepts exactly CRC_W further bits (the received CRC, MSB-first, already XORed back by the sender), using the same step rule.
  - After the last of these bits, go to DONE.
- DONE (one cycle):
  - `done`=1; `crc_out` and `crc_ok` are updated in this same cycle.
  - Generate mode: `crc_out` = data-only CRC ^ XOR_OUT, `crc_ok`=0.
  - Check mode: `crc_out` = residue ^ XOR_OUT; `crc_ok` = (residue == 0). The residue-zero property holds only for XOR_OUT=0; that is a documented restriction.
  - Next state is IDLE, or DATA if `start`=1 (back-to-back frames).
- `start` in DATA/CHECK is ignored.
- `abort` in DATA/CHECK: go to IDLE next cycle, no `done`, `crc_out`/`crc_ok` unchanged. `abort` has priority over a simultaneous last bit and over `start`.
- `in_valid` outside DATA/CHECK: ignored, no state change.
- Bit counter width: $clog2(FRAME_BITS+CRC_W+1). No wrap occurs within a legal frame.

## Timing
- Reset values:
  - state=IDLE, `crc`=INIT, counter=0;
  - `in_ready`=0, `busy`=0, `done`=0, `crc_out`=0, `crc_ok`=0.
- `start` accepted at edge N: `in_ready`=1 and `busy`=1 from cycle N+1.
- Last bit accepted at edge M: `done`=1 in cycle M+1, `in_ready`=0 in cycle M+1.
- Minimum frame length in cycles: FRAME_BITS (+CRC_W in check mode) + 2, including the `start` cycle and the DONE cycle.
- `busy`=1 in DATA and CHECK only.
- `in_ready` is a registered state decode with no combinational path from `in_valid`.
- Reset asserted mid-frame: next cycle is IDLE with all reset values; the `done`/`crc_out` of the interrupted frame are lost.

## Structure
- Package `crc_pkg` holds:
  - `crc_state_e` enum (IDLE/DATA/CHECK/DONE);
  - function `crc_step(crc, bit, poly)` implementing the step rule;
  - named polynomial constants `CRC16_CCITT=16'h1021`, `CRC8_ATM=8'h07`, `CRC32_IEEE=32'h04C11DB7`.
- One sub-module, `crc_frame_ctrl`, holds the FSM and bit counter and drives `in_ready`/`busy`/`done`/step-enable. The top level holds the CRC register and output registers.

## Test plan
- CRC_W=16, POLY=1021, INIT=0, FRAME_BITS=72, ASCII "123456789" streamed MSB-first with `in_valid` always 1 -> `done` pulse exactly 73 cycles after the `start` edge, `crc_out`=16'h31C3.
- Same data with INIT=16'hFFFF and randomised `in_valid` gaps -> `crc_out`=16'h29B1; `in_ready`=1 throughout the frame.
- Check mode, "123456789" followed by 16'h31C3 -> `crc_ok`=1, `crc_out`=0. Same stimulus with payload bit 5 flipped -> `crc_ok`=0.
- `abort` raised on the 40th bit; then a new frame "123456789" -> no `done` for the aborted frame; second frame gives 16'h31C3.
- `start` held high in DONE -> new frame begins with no idle cycle; two consecutive correct CRCs. `start` pulsed mid-frame -> ignored, result unchanged.
- `rst` asserted mid-frame -> all outputs 0 and IDLE on the next cycle. CRC_W=8, POLY=07, FRAME_BITS=8, data 8'h01 -> `crc_out`=8'h07.

Source files
------------

// File: rtl/crc_pkg.sv
// Shared types, polynomial constants and the single-bit CRC step used by the
// serial CRC engine.
package crc_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StData,
      StCheck,
      StDone
   } crc_state_e;

   localparam logic [15:0] CRC16_CCITT = 16'h1021;
   localparam logic [7:0]  CRC8_ATM    = 8'h07;
   localparam logic [31:0] CRC32_IEEE  = 32'h04C11DB7;

   // Operates on a 32-bit container; bits at and above width are forced to zero.
   function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic din,
                                            input logic [31:0] poly, input int unsigned width);
      logic        fb;
      logic [31:0] mask;
      fb   = crc[width-1] ^ din;
      mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      return ((crc << 1) ^ (fb ? poly : 32'd0)) & mask;
   endfunction

endpackage

// File: rtl/crc_frame_ctrl.sv
// Frame sequencer for the serial CRC engine: state machine, bit counter and
// the handshake/status outputs.
module crc_frame_ctrl #(
   parameter int unsigned CRC_W      = 16,
   parameter int unsigned FRAME_BITS = 32
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic check_en,
   input  logic abort,
   input  logic in_valid,
   output logic in_ready,
   output logic busy,
   output logic done,
   output logic step_en,
   output logic load,
   output logic frame_end,
   output logic check_mode
);
   import crc_pkg::*;

   localparam int unsigned CNT_W = $clog2(FRAME_BITS + CRC_W + 1);
   localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(FRAME_BITS - 1);
   localparam logic [CNT_W-1:0] CHECK_LAST = CNT_W'(FRAME_BITS + CRC_W - 1);

   crc_state_e       state;
   logic [CNT_W-1:0] cnt;
   logic             chk;
   logic             data_last;
   logic             check_last;

   assign load       = start & ((state == StIdle) | (state == StDone));
   assign step_en    = in_ready & in_valid & ~abort;
   assign data_last  = (state == StData) & (cnt == DATA_LAST);
   assign check_last = (state == StCheck) & (cnt == CHECK_LAST);
   // Counter runs on through the check bits, so one compare marks each phase end.
   assign frame_end  = step_en & ((data_last & ~chk) | check_last);
   assign check_mode = chk;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= StIdle;
         cnt      <= '0;
         chk      <= 1'b0;
         in_ready <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            StIdle, StDone: begin
               if (start) begin
                  state    <= StData;
                  cnt      <= '0;
                  chk      <= check_en;
                  in_ready <= 1'b1;
                  busy     <= 1'b1;
               end else begin
                  state <= StIdle;
               end
            end
            StData, StCheck: begin
               if (abort) begin
                  state    <= StIdle;
                  in_ready <= 1'b0;
                  busy     <= 1'b0;
               end else if (step_en) begin
                  cnt <= cnt + 1'b1;
                  if (frame_end) begin
                     state    <= StDone;
                     in_ready <= 1'b0;
                     busy     <= 1'b0;
                     done     <= 1'b1;
                  end else if (data_last) begin
                     state <= StCheck;
                  end
               end
            end
            default: begin
               state    <= StIdle;
               in_ready <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/crc_serial_engine.sv
// Bit-serial CRC generator/checker: CRC register and result registers, with
// framing delegated to crc_frame_ctrl.
module crc_serial_engine #(
   parameter int unsigned      CRC_W      = 16,
   parameter logic [CRC_W-1:0] POLY       = 16'h1021,
   parameter logic [CRC_W-1:0] INIT       = '0,
   parameter logic [CRC_W-1:0] XOR_OUT    = '0,
   parameter int unsigned      FRAME_BITS = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             check_en,
   input  logic             abort,
   input  logic             in_valid,
   input  logic             in_bit,
   output logic             in_ready,
   output logic             busy,
   output logic             done,
   output logic [CRC_W-1:0] crc_out,
   output logic             crc_ok
);
   import crc_pkg::*;

   logic [CRC_W-1:0] crc;
   logic [CRC_W-1:0] crc_next;
   logic [31:0]      step_full;
   logic             unused_step;
   logic             step_en;
   logic             load;
   logic             frame_end;
   logic             check_mode;

   crc_frame_ctrl #(
      .CRC_W     (CRC_W),
      .FRAME_BITS(FRAME_BITS)
   ) u_ctrl (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .check_en  (check_en),
      .abort     (abort),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .busy      (busy),
      .done      (done),
      .step_en   (step_en),
      .load      (load),
      .frame_end (frame_end),
      .check_mode(check_mode)
   );

   assign step_full   = crc_step(32'(crc), in_bit, 32'(POLY), CRC_W);
   assign crc_next    = step_full[CRC_W-1:0];
   assign unused_step = ^step_full;

   // Results latch on the final accepted bit so they are visible in the done cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         crc     <= INIT;
         crc_out <= '0;
         crc_ok  <= 1'b0;
      end else begin
         if (load) begin
            crc <= INIT;
         end else if (step_en) begin
            crc <= crc_next;
         end
         if (frame_end) begin
            crc_out <= crc_next ^ XOR_OUT;
            crc_ok  <= check_mode & (crc_next == '0);
         end
      end
   end

endmodule
